// File: rtl/render_stream_arbiter_if.sv
// Bundle between the pixel renderers and the stream arbiter.
// master = renderer/driver side, slave = arbiter side.
interface render_stream_arbiter_if #(
  parameter int N_CH    = 2,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]         req, grant, src_plot, src_finished;
  logic [N_CH*X_W-1:0]     src_x;
  logic [N_CH*Y_W-1:0]     src_y;
  logic [N_CH*COLOR_W-1:0] src_color;
  logic [X_W-1:0]          out_x;
  logic [Y_W-1:0]          out_y;
  logic [COLOR_W-1:0]      out_color;
  logic                    plot, busy, done_pulse, timeout_pulse;
  logic [CH_W-1:0]         active_ch;

  modport master (
    output req, src_x, src_y, src_color, src_plot, src_finished,
    input  grant, out_x, out_y, out_color, plot, busy, active_ch, done_pulse, timeout_pulse
  );
  modport slave (
    input  req, src_x, src_y, src_color, src_plot, src_finished,
    output grant, out_x, out_y, out_color, plot, busy, active_ch, done_pulse, timeout_pulse
  );
endinterface

// File: rtl/render_stream_arbiter.sv
// Grants one of N_CH pixel renderers the VGA write port until it finishes (or the watchdog fires).
// Define RENDER_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module render_stream_arbiter #(
  parameter int N_CH    = 2,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3,
  parameter int TIMEOUT = 0,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input logic                    clock,
  input logic                    enable,
  render_stream_arbiter_if.slave bus
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [N_CH-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    ch_q, ch_d, rr_q, rr_d, sel_ch;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic               first_q, first_d, plot_q, plot_d, done_q, done_d, to_q, to_d;
  logic               sel_found, fin_c, to_hit;
  logic [N_CH-1:0]    req_sh, fin_sh, plot_sh;
  int                 idx;

  // Pick the next channel from the live request vector.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    idx       = 0;
    req_sh    = '0;
    for (int k = 0; k < N_CH; k++) begin
`ifdef RENDER_ARB_ROUND_ROBIN_EN
      idx = (int'(rr_q) + k) % N_CH;
`else
      idx = k;
`endif
      req_sh = bus.req >> idx;
      if (!sel_found && req_sh[0]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    first_d = 1'b0;
    plot_d  = 1'b0;
    done_d  = 1'b0;
    to_d    = 1'b0;
    fin_sh  = bus.src_finished >> ch_q;
    plot_sh = bus.src_plot >> ch_q;
    // A sticky done left over from the previous grant is masked in the first RUN cycle.
    fin_c   = fin_sh[0] & ~first_q;
    to_hit  = (TIMEOUT > 0) && (int'(wd_q) == TIMEOUT - 1);
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = RUN;
          ch_d    = sel_ch;
          grant_d = N_CH'(1) << sel_ch;
          first_d = 1'b1;
          wd_d    = '0;
        end
      end
      RUN: begin
        wd_d = wd_q + 1'b1;
        if (fin_c || to_hit) begin
          state_d = RELEASE;
          grant_d = '0;
          done_d  = fin_c;
          to_d    = ~fin_c;
          rr_d    = (int'(ch_q) == N_CH - 1) ? '0 : ch_q + 1'b1;
        end else begin
          x_d    = bus.src_x[int'(ch_q)*X_W +: X_W];
          y_d    = bus.src_y[int'(ch_q)*Y_W +: Y_W];
          col_d  = bus.src_color[int'(ch_q)*COLOR_W +: COLOR_W];
          plot_d = plot_sh[0];
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge enable) begin
    if (!enable) begin
      state_q <= IDLE;
      grant_q <= '0;
      ch_q    <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      first_q <= 1'b0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      first_q <= first_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.out_x         = x_q;
  assign bus.out_y         = y_q;
  assign bus.out_color     = col_q;
  assign bus.plot          = plot_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.active_ch     = ch_q;
  assign bus.done_pulse    = done_q;
  assign bus.timeout_pulse = to_q;
endmodule

// File: tb/tb_render_stream_arbiter.sv
// Directed bench for render_stream_arbiter: dut_a has TIMEOUT=8, dut_b has TIMEOUT=2, both share stimulus.
module tb_render_stream_arbiter;
  localparam int N = 2, XW = 9, YW = 8, CW = 3;

  logic clock = 1'b0;
  logic enable = 1'b0;
  always #5 clock = ~clock;

  render_stream_arbiter_if #(.N_CH(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) ba();
  render_stream_arbiter_if #(.N_CH(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bb();

  assign bb.req          = ba.req;
  assign bb.src_x        = ba.src_x;
  assign bb.src_y        = ba.src_y;
  assign bb.src_color    = ba.src_color;
  assign bb.src_plot     = ba.src_plot;
  assign bb.src_finished = ba.src_finished;

  render_stream_arbiter #(.N_CH(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .TIMEOUT(8))
    dut_a (.clock(clock), .enable(enable), .bus(ba));
  render_stream_arbiter #(.N_CH(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .TIMEOUT(2))
    dut_b (.clock(clock), .enable(enable), .bus(bb));

  typedef struct {
    logic [1:0] req, fin;
    int         sx;
    logic [1:0] g;
    logic       p, b, d;
    int         pix;
  } vec_t;

  int tests = 0, fails = 0;

  function automatic int pix(input int x, input int y, input int c);
    return (x << 11) | (y << 3) | c;
  endfunction

  function automatic int pix_a();
    return pix(int'(ba.out_x), int'(ba.out_y), int'(ba.out_color));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    enable = 1'b0;
    ba.req = '0;
    ba.src_finished = '0;
    tick();
    @(negedge clock);
    enable = 1'b1;
  endtask

  // Wait for a grant, check it, let it run two cycles, finish it, check the release gap.
  task automatic serve(input int ch, input int k);
    int w = 0;
    while (ba.grant == '0 && w < 10) begin
      tick();
      w++;
    end
    chk($sformatf("serve%0d grant", k), int'(ba.grant), 1 << ch);
    chk($sformatf("serve%0d active_ch", k), int'(ba.active_ch), ch);
    tick();
    chk($sformatf("serve%0d plot", k), int'(ba.plot), 1);
    chk($sformatf("serve%0d pix", k), pix_a(), (ch == 0) ? pix(10, 20, 3) : pix(100, 200, 5));
    ba.src_finished = 2'b01 << ch;
    tick();
    chk($sformatf("serve%0d rel grant", k), int'(ba.grant), 0);
    chk($sformatf("serve%0d rel plot", k), int'(ba.plot), 0);
    chk($sformatf("serve%0d rel done", k), int'(ba.done_pulse), 1);
    ba.src_finished = '0;
    tick();
    chk($sformatf("serve%0d gap grant", k), int'(ba.grant), 0);
    chk($sformatf("serve%0d gap busy", k), int'(ba.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int   order[3];

    ba.req          = '0;
    ba.src_finished = '0;
    ba.src_plot     = 2'b11;
    ba.src_x        = {9'd100, 9'd10};
    ba.src_y        = {8'd200, 8'd20};
    ba.src_color    = {3'd5, 3'd3};

    vt[0] = '{req: 2'b01, fin: 2'b00, sx: 10, g: 2'b01, p: 0, b: 1, d: 0, pix: 0};
    vt[1] = '{req: 2'b01, fin: 2'b00, sx: 10, g: 2'b01, p: 1, b: 1, d: 0, pix: pix(10, 20, 3)};
    vt[2] = '{req: 2'b01, fin: 2'b00, sx: 11, g: 2'b01, p: 1, b: 1, d: 0, pix: pix(11, 20, 3)};
    vt[3] = '{req: 2'b01, fin: 2'b00, sx: 12, g: 2'b01, p: 1, b: 1, d: 0, pix: pix(12, 20, 3)};
    vt[4] = '{req: 2'b01, fin: 2'b00, sx: 13, g: 2'b01, p: 1, b: 1, d: 0, pix: pix(13, 20, 3)};
    vt[5] = '{req: 2'b01, fin: 2'b01, sx: 13, g: 2'b00, p: 0, b: 1, d: 1, pix: pix(13, 20, 3)};
    vt[6] = '{req: 2'b00, fin: 2'b00, sx: 13, g: 2'b00, p: 0, b: 0, d: 0, pix: pix(13, 20, 3)};

    // Reset state
    #2;
    chk("rst grant", int'(ba.grant), 0);
    chk("rst plot", int'(ba.plot), 0);
    chk("rst busy", int'(ba.busy), 0);
    chk("rst active_ch", int'(ba.active_ch), 0);
    chk("rst pulses", int'({ba.done_pulse, ba.timeout_pulse}), 0);
    chk("rst pix", pix_a(), 0);

    // 1: single channel, table-driven
    do_reset();
    for (int i = 0; i < 7; i++) begin
      ba.req          = vt[i].req;
      ba.src_finished = vt[i].fin;
      ba.src_x        = {9'd100, 9'(vt[i].sx)};
      tick();
      chk($sformatf("t1[%0d] grant", i), int'(ba.grant), int'(vt[i].g));
      chk($sformatf("t1[%0d] plot", i), int'(ba.plot), int'(vt[i].p));
      chk($sformatf("t1[%0d] busy", i), int'(ba.busy), int'(vt[i].b));
      chk($sformatf("t1[%0d] done", i), int'(ba.done_pulse), int'(vt[i].d));
      chk($sformatf("t1[%0d] timeout", i), int'(ba.timeout_pulse), 0);
      chk($sformatf("t1[%0d] pix", i), pix_a(), vt[i].pix);
    end
    ba.src_x = {9'd100, 9'd10};

    // 2/3: both requesting, three grants
`ifdef RENDER_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 0};
`else
    order = '{0, 0, 0};
`endif
    do_reset();
    ba.req = 2'b11;
    for (int k = 0; k < 3; k++) serve(order[k], k);
    ba.req = '0;

    // 4: watchdog on dut_a, then the other requester is served
    do_reset();
    ba.req = 2'b10;
    tick();
    chk("t4 grant", int'(ba.grant), 2);
    repeat (7) tick();
    chk("t4 cyc8 grant", int'(ba.grant), 2);
    chk("t4 cyc8 timeout", int'(ba.timeout_pulse), 0);
    ba.req = 2'b11;
    tick();
    chk("t4 rel timeout", int'(ba.timeout_pulse), 1);
    chk("t4 rel done", int'(ba.done_pulse), 0);
    chk("t4 rel grant", int'(ba.grant), 0);
    chk("t4 rel plot", int'(ba.plot), 0);
    tick();
    chk("t4 idle timeout", int'(ba.timeout_pulse), 0);
    tick();
    serve(0, 4);
    ba.req = '0;

    // 5: finished held from the first grant cycle; dut_b also times out that cycle
    do_reset();
    ba.req = 2'b01;
    ba.src_finished = 2'b01;
    tick();
    chk("t5 a grant", int'(ba.grant), 1);
    chk("t5 b grant", int'(bb.grant), 1);
    tick();
    chk("t5 a hold", int'(ba.grant), 1);
    chk("t5 a nodone", int'(ba.done_pulse), 0);
    chk("t5 b hold", int'(bb.grant), 1);
    chk("t5 b nopulse", int'({bb.done_pulse, bb.timeout_pulse}), 0);
    tick();
    chk("t5 a rel", int'({ba.grant, ba.done_pulse, ba.timeout_pulse}), 3'b0_1_0 | 0);
    chk("t5 b done only", int'({bb.grant, bb.done_pulse, bb.timeout_pulse}), 3'b0_1_0 | 0);
    ba.src_finished = '0;
    tick();
    tick();
    chk("t5 b regrant", int'(bb.grant), 1);
    tick();
    chk("t5 b cyc2", int'(bb.grant), 1);
    tick();
    chk("t5 b timeout", int'({bb.grant, bb.done_pulse, bb.timeout_pulse}), 1);
    chk("t5 a still run", int'(ba.grant), 1);

    // 6: asynchronous reset mid-RUN, then clean restart
    do_reset();
    ba.req = 2'b01;
    tick();
    tick();
    tick();
    chk("t6 plot before", int'(ba.plot), 1);
    #2;
    enable = 1'b0;
    #1;
    chk("t6 async grant", int'(ba.grant), 0);
    chk("t6 async plot", int'(ba.plot), 0);
    chk("t6 async busy", int'(ba.busy), 0);
    chk("t6 async pix", pix_a(), 0);
    @(negedge clock);
    enable = 1'b1;
    tick();
    chk("t6 restart grant", int'(ba.grant), 1);
    chk("t6 restart ch", int'(ba.active_ch), 0);
    tick();
    chk("t6 restart plot", int'(ba.plot), 1);
    chk("t6 restart pix", pix_a(), pix(10, 20, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/render_stream_arbiter.md
Name: render_stream_arbiter

Overview:
- Parametrised successor to the page renderer's fixed rect/text pixel mux.
- Arbitrates N pixel-stream renderers (rect, text, future image/line units) onto the single VGA write port.
- Grants one renderer at a time, holds the grant until that renderer reports finished, then releases it and serves the next requester.
- Adds registered output, round-robin fairness and a hang watchdog, none of which the earlier mux had.

Parameters:
- N_CH, 2, number of renderer channels (>=1)
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- COLOR_W, 3, colour width
- TIMEOUT, 0, max cycles a grant may be held; 0 disables the watchdog
- CH_W, derived, max(1, clog2(N_CH)), channel index width

Ports:
- clock  in  1  system clock, rising edge
- enable  in  1  asynchronous active-low reset (enable / ~reset)
- req  in  N_CH  per-channel request, level
- grant  out  N_CH  one-hot renderer enable; drives each renderer's enable input
- src_x  in  N_CH*X_W  packed x streams; channel c at [c*X_W +: X_W]
- src_y  in  N_CH*Y_W  packed y streams
- src_color  in  N_CH*COLOR_W  packed colour streams
- src_plot  in  N_CH  per-channel write strobe
- src_finished  in  N_CH  per-channel done; sticky until grant drops
- out_x  out  X_W  registered pixel x
- out_y  out  Y_W  registered pixel y
- out_color  out  COLOR_W  registered pixel colour
- plot  out  1  registered VGA write enable
- busy  out  1  high in any state other than IDLE
- active_ch  out  CH_W  index of the current or most recent channel
- done_pulse  out  1  one-cycle pulse on normal release
- timeout_pulse  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (enable=0, async): state IDLE; all outputs 0; rr pointer 0; watchdog counter 0.
- IDLE:
  - If any req bit is set, select channel c (see Optional Feature), latch active_ch=c and go to RUN.
  - grant[c] rises on the cycle after selection.
- RUN:
  - grant = one-hot(c).
  - Each cycle, out_x/out_y/out_color/plot register src_*[c] and src_plot[c]. Latency is 1 cycle from source to output.
  - Non-selected sources are never visible on the outputs.
- RUN exit:
  - src_finished[c]=1 in any RUN cycle except the first -> RELEASE, done_pulse=1.
  - The first RUN cycle ignores finished, to mask a stale sticky done.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to RUN and increments each RUN cycle.
  - At count TIMEOUT-1 without finished: RELEASE, timeout_pulse=1.
  - If finished and timeout occur in the same cycle, finished wins: done_pulse only.
- RELEASE (exactly 1 cycle):
  - grant=0 and plot=0; no pixel is written.
  - rr pointer = (c+1) mod N_CH.
  - Then IDLE.
  - A new grant can rise at the earliest 2 cycles after RELEASE.
- Request changes:
  - req[c] dropping during RUN is ignored; the grant holds until finished or timeout.
  - New requests during RUN wait.
- Outputs by state:
  - plot=0 in IDLE and RELEASE.
  - out_x/out_y/out_color hold their last value there.
- Other rules:
  - busy=1 in RUN and RELEASE.
  - grant is never multi-hot.
  - N_CH=1: channel 0 is always selected and the pointer stays 0.
- Reset mid-RUN: grant, plot and all pulses drop immediately (asynchronous); no partial state survives.

Optional Feature:
- Macro: RENDER_ARB_ROUND_ROBIN_EN.
- Defined: select the first set req bit at or after the rr pointer, wrapping around.
- Undefined: fixed priority, lowest index wins; the rr pointer is still maintained but unused.

Test Plan:
1. Reset, then req=2'b01. Ch0 emits plot at (10,20) colour 3 for 4 cycles, then finished -> grant=01 one cycle after req; out_* follow with 1-cycle lag; done_pulse one cycle; grant=00 in RELEASE.
2. RR build, req=2'b11 held for 3 grants -> order ch0, ch1, ch0; 1-cycle RELEASE gap with plot=0 between grants; active_ch 0,1,0.
3. No RR build, req=2'b11 held -> ch0 wins every time; ch1 starves while req[0] stays high.
4. TIMEOUT=8, granted channel never asserts finished -> timeout_pulse at RUN cycle 8; grant drops; next requester is served.
5. finished held high from the first grant cycle -> first-cycle finished ignored; release at cycle 2. Finished and timeout in the same cycle (TIMEOUT=2) -> done_pulse only.
6. enable low in the middle of RUN with plot active -> grant=0, plot=0, busy=0 asynchronously; after release, req=01 restarts cleanly from ch0.
